// File: rtl/apb_mem_responder.sv
// APB3 memory responder: word-addressed local RAM behind an APB completer port, with a
// fixed number of wait states and an error response for misaligned or out-of-range accesses.
module apb_mem_responder #(
    parameter int unsigned        ADDR_W      = 32,
    parameter int unsigned        DATA_W      = 32,
    parameter int unsigned        MEM_DEPTH   = 1024,
    parameter logic [ADDR_W-1:0]  BASE_ADDR   = '0,
    parameter int unsigned        WAIT_STATES = 0
) (
    input  logic              pclk_i,
    input  logic              prstn_i,
    input  logic [ADDR_W-1:0] paddr_i,
    input  logic [DATA_W-1:0] pwdata_i,
    input  logic              psel_i,
    input  logic              pwrite_i,
    input  logic              penable_i,
    output logic [DATA_W-1:0] prdata_o,
    output logic              pready_o,
    output logic              pslverr_o
);

    localparam int unsigned       IDX_W    = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam logic [ADDR_W-1:0] DEPTH_A  = ADDR_W'(MEM_DEPTH);
    localparam logic [3:0]        WAIT_CNT = 4'(WAIT_STATES);

    typedef enum logic [0:0] {StIdle, StAccess} state_e;

    state_e            state_q;
    logic [DATA_W-1:0] mem [MEM_DEPTH];
    logic [IDX_W-1:0]  idx_q;
    logic              write_q;
    logic              err_q;
    logic [DATA_W-1:0] wdata_q;
    logic [3:0]        cnt_q;

    logic [ADDR_W-1:0] offset;
    logic [ADDR_W-1:0] word_idx;
    logic              setup_err;
    logic [IDX_W-1:0]  setup_idx;
    logic              rsp_err;
    logic              rsp_write;
    logic [IDX_W-1:0]  rsp_idx;
    logic              mem_we;

    always_comb begin
        offset    = paddr_i - BASE_ADDR;
        word_idx  = offset >> 2;
        setup_err = (paddr_i[1:0] != 2'b00) || (paddr_i < BASE_ADDR) || (word_idx >= DEPTH_A);
        setup_idx = word_idx[IDX_W-1:0];
        // With zero wait states the response is formed from the live setup-phase inputs.
        rsp_err   = (state_q == StIdle) ? setup_err : err_q;
        rsp_write = (state_q == StIdle) ? pwrite_i  : write_q;
        rsp_idx   = (state_q == StIdle) ? setup_idx : idx_q;
        mem_we    = prstn_i && (state_q == StAccess) && psel_i && penable_i && pready_o &&
                    write_q && !err_q;
    end

    always_ff @(posedge pclk_i) begin
        if (mem_we) begin
            mem[idx_q] <= wdata_q;
        end
    end

    always_ff @(posedge pclk_i) begin
        if (!prstn_i) begin
            state_q   <= StIdle;
            pready_o  <= 1'b0;
            pslverr_o <= 1'b0;
            prdata_o  <= '0;
            cnt_q     <= '0;
            idx_q     <= '0;
            write_q   <= 1'b0;
            err_q     <= 1'b0;
            wdata_q   <= '0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (psel_i && !penable_i) begin
                        idx_q   <= setup_idx;
                        write_q <= pwrite_i;
                        wdata_q <= pwdata_i;
                        err_q   <= setup_err;
                        cnt_q   <= WAIT_CNT;
                        state_q <= StAccess;
                        if (WAIT_STATES == 0) begin
                            pready_o  <= 1'b1;
                            pslverr_o <= rsp_err;
                            if (rsp_err) begin
                                prdata_o <= '0;
                            end else if (!rsp_write) begin
                                prdata_o <= mem[rsp_idx];
                            end
                        end
                    end
                end
                StAccess: begin
                    if (!psel_i) begin
                        state_q   <= StIdle;
                        pready_o  <= 1'b0;
                        pslverr_o <= 1'b0;
                    end else if (pready_o) begin
                        if (penable_i) begin
                            state_q   <= StIdle;
                            pready_o  <= 1'b0;
                            pslverr_o <= 1'b0;
                        end
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                        if (cnt_q == 4'd1) begin
                            pready_o  <= 1'b1;
                            pslverr_o <= rsp_err;
                            if (rsp_err) begin
                                prdata_o <= '0;
                            end else if (!rsp_write) begin
                                prdata_o <= mem[rsp_idx];
                            end
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_apb_mem_responder.sv
// Bench for apb_mem_responder: three instances (0, 3 and 2 wait states) on a shared bus,
// checked against a reference memory model through an expected-response queue.
module tb_apb_mem_responder;

    logic        pclk  = 1'b0;
    logic        prstn = 1'b0;
    logic [31:0] paddr;
    logic [31:0] pwdata;
    logic        pwrite;
    logic        penable;
    logic        psel_v    [3];
    logic [31:0] prdata_v  [3];
    logic        pready_v  [3];
    logic        pslverr_v [3];

    always #5 pclk = ~pclk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        apb_mem_responder #(
            .WAIT_STATES(g == 0 ? 0 : (g == 1 ? 3 : 2))
        ) u_dut (
            .pclk_i   (pclk),
            .prstn_i  (prstn),
            .paddr_i  (paddr),
            .pwdata_i (pwdata),
            .psel_i   (psel_v[g]),
            .pwrite_i (pwrite),
            .penable_i(penable),
            .prdata_o (prdata_v[g]),
            .pready_o (pready_v[g]),
            .pslverr_o(pslverr_v[g])
        );
    end

    typedef struct {
        logic [31:0] data;
        logic        err;
        logic        is_read;
        int          cycles;
    } exp_t;

    int          ws_of [3] = '{0, 3, 2};
    exp_t        sb [$];
    logic [31:0] model [int];
    int          n_checks = 0;
    int          n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // One complete APB transfer on instance k; leaves the bus ready for a back-to-back setup.
    task automatic xfer(input int k, input logic wr, input logic [31:0] addr,
                        input logic [31:0] data);
        exp_t        e;
        exp_t        r;
        int          cyc;
        int          key;
        logic        err;
        logic [31:0] widx;
        widx      = addr >> 2;
        err       = (addr[1:0] != 2'b00) || (widx >= 32'd1024);
        key       = k * 65536 + int'(widx[9:0]);
        e.err     = err;
        e.is_read = !wr;
        e.cycles  = 2 + ws_of[k];
        e.data    = (err || wr) ? 32'h0 : model[key];
        if (wr && !err) model[key] = data;
        sb.push_back(e);

        paddr     = addr;
        pwdata    = data;
        pwrite    = wr;
        psel_v[k] = 1'b1;
        penable   = 1'b0;
        @(posedge pclk); #1;
        penable = 1'b1;
        cyc     = 2;
        while (!pready_v[k] && cyc < 40) begin
            @(posedge pclk); #1;
            cyc++;
        end
        r = sb.pop_front();
        if (!pready_v[k]) begin
            check_eq($sformatf("pready_timeout i%0d a%h", k, addr), 32'(pready_v[k]), 32'd1);
        end else begin
            check_eq($sformatf("cycles i%0d a%h", k, addr), 32'(cyc), 32'(r.cycles));
            check_eq($sformatf("pslverr i%0d a%h", k, addr), 32'(pslverr_v[k]), 32'(r.err));
            if (r.is_read) begin
                check_eq($sformatf("prdata i%0d a%h", k, addr), prdata_v[k], r.data);
            end
        end
        @(posedge pclk); #1;
        check_eq($sformatf("pready_clr i%0d a%h", k, addr), 32'(pready_v[k]), 32'd0);
        psel_v[k] = 1'b0;
        penable   = 1'b0;
    endtask

    initial begin
        logic seen_ready;
        for (int i = 0; i < 3; i++) psel_v[i] = 1'b0;
        paddr   = '0;
        pwdata  = '0;
        pwrite  = 1'b0;
        penable = 1'b0;
        repeat (3) @(posedge pclk);
        #1;
        for (int i = 0; i < 3; i++) begin
            check_eq($sformatf("rst_pready i%0d", i), 32'(pready_v[i]), 32'd0);
            check_eq($sformatf("rst_pslverr i%0d", i), 32'(pslverr_v[i]), 32'd0);
            check_eq($sformatf("rst_prdata i%0d", i), prdata_v[i], 32'd0);
        end
        prstn = 1'b1;
        @(posedge pclk); #1;

        // Zero-wait write/read, then three-wait write/read.
        xfer(0, 1'b1, 32'h10, 32'hDEAD_BEEF);
        xfer(0, 1'b0, 32'h10, 32'h0);
        xfer(1, 1'b1, 32'h0, 32'h1234_5678);
        xfer(1, 1'b0, 32'h0, 32'h0);

        // Error responses; a misaligned write near 0x10 must leave that word intact.
        xfer(0, 1'b1, 32'h1002, 32'h0BAD_0001);
        xfer(0, 1'b1, 32'd4096, 32'h0BAD_0002);
        xfer(0, 1'b1, 32'h12, 32'h0BAD_0003);
        xfer(0, 1'b0, 32'h10, 32'h0);
        xfer(0, 1'b0, 32'd4096, 32'h0);

        // Back-to-back with no idle cycles.
        xfer(0, 1'b1, 32'h0, 32'h0000_0A00);
        xfer(0, 1'b1, 32'h4, 32'h0000_0A04);
        xfer(0, 1'b1, 32'h8, 32'h0000_0A08);
        xfer(0, 1'b0, 32'h8, 32'h0);
        xfer(0, 1'b0, 32'h4, 32'h0);
        xfer(0, 1'b0, 32'h0, 32'h0);
        @(posedge pclk); #1;

        // Reset during the first access cycle of a waited write.
        xfer(2, 1'b1, 32'h20, 32'h0000_0001);
        xfer(2, 1'b0, 32'h20, 32'h0);
        paddr     = 32'h20;
        pwdata    = 32'hAAAA_5555;
        pwrite    = 1'b1;
        psel_v[2] = 1'b1;
        @(posedge pclk); #1;
        penable = 1'b1;
        prstn   = 1'b0;
        @(posedge pclk); #1;
        check_eq("midrst_pready", 32'(pready_v[2]), 32'd0);
        check_eq("midrst_pslverr", 32'(pslverr_v[2]), 32'd0);
        check_eq("midrst_prdata", prdata_v[2], 32'd0);
        prstn     = 1'b1;
        psel_v[2] = 1'b0;
        penable   = 1'b0;
        @(posedge pclk); #1;
        xfer(2, 1'b0, 32'h20, 32'h0);

        // Abort a waited write by dropping psel.
        xfer(1, 1'b1, 32'h24, 32'h0);
        paddr      = 32'h24;
        pwdata     = 32'hFFFF_0000;
        pwrite     = 1'b1;
        psel_v[1]  = 1'b1;
        seen_ready = 1'b0;
        @(posedge pclk); #1;
        penable = 1'b1;
        @(posedge pclk); #1;
        seen_ready |= pready_v[1];
        psel_v[1] = 1'b0;
        penable   = 1'b0;
        repeat (5) begin
            @(posedge pclk); #1;
            seen_ready |= pready_v[1];
        end
        check_eq("abort_no_pready", 32'(seen_ready), 32'd0);
        xfer(1, 1'b0, 32'h24, 32'h0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running, expected finished");
        $fatal(1, "timeout");
    end

endmodule
